// File: rtl/fab_cfg_pkg.sv
// Shared types and header field layout for the column configuration-frame loader.
package fab_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_SKIP,
      ST_STROBE,
      ST_GAP
   } cfl_state_t;

   localparam logic [7:0] CFG_SYNC = 8'hFA;

   // Header word: [31:24] sync, [23:16] column, [8] data parity, [7:0] frame index
   localparam int SYNC_LSB = 24;
   localparam int SYNC_W   = 8;
   localparam int COL_LSB  = 16;
   localparam int COL_W    = 8;
   localparam int IDX_LSB  = 0;
   localparam int IDX_W    = 8;
   localparam int PAR_BIT  = 8;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Converts a frame index into a one-hot write strobe; out-of-range or idle gives all zeros.
module frame_strobe_decoder
   import fab_cfg_pkg::*;
#(
   parameter int MAX_FRAMES = 20
) (
   input  logic [IDX_W-1:0]      index,
   input  logic                  fire,
   output logic [MAX_FRAMES-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < MAX_FRAMES; i++) begin
         onehot[i] = fire && (int'(index) == i);
      end
   end

endmodule

// File: rtl/column_frame_loader.sv
// Header/data frame loader driving FrameData and a one-hot FrameStrobe down one fabric column.
// Optional data-word parity checking is enabled by defining FRAME_PARITY_EN.
module column_frame_loader
   import fab_cfg_pkg::*;
#(
   parameter int         FRAME_BITS = 32,
   parameter int         MAX_FRAMES = 20,
   parameter logic [7:0] COL_ID     = 8'd0
) (
   input  logic                  UserCLK,
   input  logic                  RESET,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [FRAME_BITS-1:0] cfg_data,
   output logic [FRAME_BITS-1:0] FrameData,
   output logic [MAX_FRAMES-1:0] FrameStrobe,
   output logic                  err_sync,
   output logic                  err_range,
`ifdef FRAME_PARITY_EN
   output logic                  err_parity,
`endif
   output logic [15:0]           frames_written
);

   cfl_state_t              state;
   logic [IDX_W-1:0]        frame_idx;
   logic                    accept;
   logic                    fire;
   logic                    par_ok;
   logic [MAX_FRAMES-1:0]   strobe_next;
   logic [SYNC_W-1:0]       hdr_sync;
   logic [COL_W-1:0]        hdr_col;
   logic [IDX_W-1:0]        hdr_idx;

   assign accept   = cfg_valid && cfg_ready;
   assign hdr_sync = cfg_data[SYNC_LSB +: SYNC_W];
   assign hdr_col  = cfg_data[COL_LSB +: COL_W];
   assign hdr_idx  = cfg_data[IDX_LSB +: IDX_W];

   // The strobe is registered from the STROBE state, so it lands one cycle after FrameData settles
   assign fire = (state == ST_STROBE) && par_ok;

`ifdef FRAME_PARITY_EN
   logic hdr_par;
   logic par_match;
`else
   assign par_ok = 1'b1;
`endif

   frame_strobe_decoder #(
      .MAX_FRAMES(MAX_FRAMES)
   ) u_decoder (
      .index (frame_idx),
      .fire  (fire),
      .onehot(strobe_next)
   );

   always_ff @(posedge UserCLK) begin
      if (RESET) begin
         state          <= ST_IDLE;
         cfg_ready      <= 1'b0;
         FrameData      <= '0;
         FrameStrobe    <= '0;
         err_sync       <= 1'b0;
         err_range      <= 1'b0;
         frames_written <= 16'd0;
         frame_idx      <= '0;
`ifdef FRAME_PARITY_EN
         err_parity     <= 1'b0;
         hdr_par        <= 1'b0;
         par_match      <= 1'b1;
`endif
      end else begin
         FrameStrobe <= strobe_next;
         cfg_ready   <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (hdr_sync != CFG_SYNC) begin
                     err_sync <= 1'b1;
                  end else if (hdr_col != COL_ID) begin
                     state <= ST_SKIP;
                  end else if (int'(hdr_idx) >= MAX_FRAMES) begin
                     err_range <= 1'b1;
                     state     <= ST_SKIP;
                  end else begin
                     frame_idx <= hdr_idx;
`ifdef FRAME_PARITY_EN
                     hdr_par   <= cfg_data[PAR_BIT];
`endif
                     state     <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  FrameData <= cfg_data;
`ifdef FRAME_PARITY_EN
                  par_match <= (hdr_par == ^cfg_data);
`endif
                  cfg_ready <= 1'b0;
                  state     <= ST_STROBE;
               end
            end
            ST_SKIP: begin
               if (accept) begin
                  state <= ST_IDLE;
               end
            end
            ST_STROBE: begin
               cfg_ready <= 1'b0;
               state     <= ST_GAP;
               if (fire && (frames_written != 16'hFFFF)) begin
                  frames_written <= frames_written + 16'd1;
               end
`ifdef FRAME_PARITY_EN
               if (!par_ok) begin
                  err_parity <= 1'b1;
               end
`endif
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FRAME_PARITY_EN
   assign par_ok = par_match;
`endif

endmodule

// File: tb/tb_column_frame_loader.sv
// Directed bench for column_frame_loader: transaction-level model checked every cycle plus literal anchors.
module tb_column_frame_loader;
   import fab_cfg_pkg::*;

   localparam int         FB  = 32;
   localparam int         MF  = 20;
   localparam logic [7:0] COL = 8'd0;

   logic          UserCLK;
   logic          RESET;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [FB-1:0] cfg_data;
   logic [FB-1:0] FrameData;
   logic [MF-1:0] FrameStrobe;
   logic          err_sync;
   logic          err_range;
   logic [15:0]   frames_written;
`ifdef FRAME_PARITY_EN
   logic          err_parity;
`endif

   int checks = 0;
   int errors = 0;

   column_frame_loader #(
      .FRAME_BITS(FB),
      .MAX_FRAMES(MF),
      .COL_ID    (COL)
   ) dut (
      .UserCLK       (UserCLK),
      .RESET         (RESET),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .FrameData     (FrameData),
      .FrameStrobe   (FrameStrobe),
      .err_sync      (err_sync),
      .err_range     (err_range),
`ifdef FRAME_PARITY_EN
      .err_parity    (err_parity),
`endif
      .frames_written(frames_written)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a data word arms a two-edge countdown, strobe on the first, ready on the second
   logic [FB-1:0] m_data;
   logic [MF-1:0] m_strobe;
   logic          m_sync, m_range, m_par;
   logic [15:0]   m_cnt;
   logic          m_ready;
   int            busy;
   bit            want_data, skip_word, m_hdr_par, m_par_ok, acc, armed;
   int            m_idx;

   initial begin
      armed = 0;
      forever begin
         @(posedge UserCLK);
         if (RESET) begin
            m_data = '0; m_strobe = '0; m_sync = 0; m_range = 0; m_par = 0;
            m_cnt = 0; m_ready = 0; busy = 0; want_data = 0; skip_word = 0;
            m_idx = 0; m_hdr_par = 0; m_par_ok = 1; armed = 1;
         end else begin
            acc      = cfg_valid && m_ready;
            m_strobe = '0;
            if (busy > 0) begin
               busy--;
               if (busy == 1) begin
                  if (m_par_ok) begin
                     m_strobe = MF'(1) << m_idx;
                     if (m_cnt != 16'hFFFF) m_cnt++;
                  end else begin
                     m_par = 1;
                  end
               end
            end else if (acc) begin
               if (want_data) begin
                  m_data    = cfg_data;
                  want_data = 0;
`ifdef FRAME_PARITY_EN
                  m_par_ok  = (m_hdr_par == ^cfg_data);
`else
                  m_par_ok  = 1;
`endif
                  busy      = 2;
               end else if (skip_word) begin
                  skip_word = 0;
               end else if (cfg_data[31:24] != 8'hFA) begin
                  m_sync = 1;
               end else if (cfg_data[23:16] != COL) begin
                  skip_word = 1;
               end else if (int'(cfg_data[7:0]) >= MF) begin
                  m_range   = 1;
                  skip_word = 1;
               end else begin
                  m_idx     = int'(cfg_data[7:0]);
                  m_hdr_par = cfg_data[8];
                  want_data = 1;
               end
            end
            m_ready = (busy == 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge UserCLK);
         if (armed) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            chk("FrameData", FrameData, m_data);
            chk("FrameStrobe", 32'(FrameStrobe), 32'(m_strobe));
            chk("err_sync", 32'(err_sync), 32'(m_sync));
            chk("err_range", 32'(err_range), 32'(m_range));
            chk("frames_written", 32'(frames_written), 32'(m_cnt));
`ifdef FRAME_PARITY_EN
            chk("err_parity", 32'(err_parity), 32'(m_par));
`endif
         end
      end
   end

   // Called on a negedge; returns on the negedge after the word was accepted
   task automatic send(input logic [31:0] w);
      int n = 0;
      cfg_valid = 1'b1;
      cfg_data  = w;
      while (!cfg_ready && n < 20) begin
         @(negedge UserCLK);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(cfg_ready), 32'd1);
      @(negedge UserCLK);
      cfg_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge UserCLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET     = 1'b1;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      idle(3);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_data", FrameData, 32'd0);
      chk("rst_count", 32'(frames_written), 32'd0);
      RESET = 1'b0;
      idle(1);

      // 1: legal write to frame 3
      send(32'hFA00_0003);
      send(32'hDEAD_BEEF);
      chk("t1_data", FrameData, 32'hDEAD_BEEF);
      chk("t1_nostrobe_yet", 32'(FrameStrobe), 32'd0);
      idle(1);
      chk("t1_strobe", 32'(FrameStrobe), 32'h0000_0008);
      chk("t1_count", 32'(frames_written), 32'd1);
      idle(1);
      chk("t1_strobe_gone", 32'(FrameStrobe), 32'd0);
      chk("t1_ready_back", 32'(cfg_ready), 32'd1);

      // 2: header for another column, data word skipped
      send(32'hFA05_0001);
      send(32'h1234_5678);
      idle(2);
      chk("t2_data_held", FrameData, 32'hDEAD_BEEF);
      chk("t2_count", 32'(frames_written), 32'd1);

      // 3: bad sync, then a legal pair still writes frame 1
      send(32'h1200_0001);
      chk("t3_err_sync", 32'(err_sync), 32'd1);
      send(32'hFA00_0001);
      send(32'hA5A5_0001);
      idle(1);
      chk("t3_strobe", 32'(FrameStrobe), 32'h0000_0002);
      chk("t3_count", 32'(frames_written), 32'd2);
      idle(2);

      // 4: index 20 is out of range, following word skipped
      send(32'hFA00_0014);
      chk("t4_err_range", 32'(err_range), 32'd1);
      send(32'h0BAD_0BAD);
      idle(3);
      chk("t4_data_held", FrameData, 32'hA5A5_0001);

      // Highest legal index, then back-to-back pairs for throughput
      send(32'hFA00_0013);
      send(32'h0000_0013);
      idle(1);
      chk("top_strobe", 32'(FrameStrobe), 32'h0008_0000);
      send(32'hFA00_0000);
      send(32'h1111_1111);
      send(32'hFA00_0007);
      send(32'h7777_7777);
      idle(3);
      chk("b2b_count", 32'(frames_written), 32'd5);

      // 5: reset during the STROBE cycle suppresses the strobe
      send(32'hFA00_0004);
      send(32'hCAFE_F00D);
      RESET = 1'b1;
      idle(1);
      chk("t5_strobe", 32'(FrameStrobe), 32'd0);
      chk("t5_data", FrameData, 32'd0);
      chk("t5_errs", {30'd0, err_sync, err_range}, 32'd0);
      chk("t5_count", 32'(frames_written), 32'd0);
      RESET = 1'b0;
      idle(3);
      chk("t5_no_late_strobe", 32'(FrameStrobe), 32'd0);

`ifdef FRAME_PARITY_EN
      // 6: parity mismatch blocks strobe, correct parity writes
      send(32'hFA00_0002);
      send(32'h0000_0001);
      idle(1);
      chk("t6_nostrobe", 32'(FrameStrobe), 32'd0);
      idle(1);
      chk("t6_err_parity", 32'(err_parity), 32'd1);
      chk("t6_data_updated", FrameData, 32'h0000_0001);
      send(32'hFA00_0102);
      send(32'h0000_0001);
      idle(1);
      chk("t6_strobe", 32'(FrameStrobe), 32'h0000_0004);
      chk("t6_count", 32'(frames_written), 32'd1);
      idle(2);
`endif

      send(32'hFA00_0005);
      send(32'h5555_AAAA);
      idle(1);
      chk("recover_strobe", 32'(FrameStrobe), 32'h0000_0020);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
